// File: rtl/arbiter_merge_pkg.sv
// Shared types and constants for the two-input arbitrated merge.
package arbiter_merge_pkg;

  localparam int WIDTH_DEFAULT = 33;
  localparam int CNT_W         = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    OUT,
    BACK
  } state_e;

  // Terminal counter value for a phase lasting `cycles` clocks (0 when the phase is skipped).
  function automatic cnt_t lastCount(input int cycles);
    return (cycles > 0) ? cnt_t'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer starts out favouring request 1.
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req1_i,
  input  logic req2_i,
  input  logic en_i,
  output logic gnt1_o,
  output logic gnt2_o
);

  logic favR2_q;
  logic favR2_d;

  always_comb begin
    gnt1_o = 1'b0;
    gnt2_o = 1'b0;
    if (en_i) begin
      if (req1_i && req2_i) begin
        gnt1_o = ~favR2_q;
        gnt2_o = favR2_q;
      end else begin
        gnt1_o = req1_i;
        gnt2_o = req2_i;
      end
    end
  end

  // Any grant, contested or not, hands priority to the other input.
  always_comb begin
    favR2_d = favR2_q;
    if (gnt1_o) begin
      favR2_d = 1'b1;
    end else if (gnt2_o) begin
      favR2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favR2_q <= 1'b0;
    end else begin
      favR2_q <= favR2_d;
    end
  end

endmodule

// File: rtl/arbiter_merge_two.sv
// One-packet merge of channels R1/R2 onto O with fixed forward/backward latency.
// Optional source-tag output o_src is enabled by defining ARB_MERGE_SRC_EN.
module arbiter_merge_two
  import arbiter_merge_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int FL    = 2,
  parameter int BL    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_data,
  input  logic             r2_valid,
  output logic             r2_ready,
  input  logic [WIDTH-1:0] r2_data,
  output logic             o_valid,
  input  logic             o_ready,
`ifdef ARB_MERGE_SRC_EN
  output logic             o_src,
`endif
  output logic [WIDTH-1:0] o_data
);

  localparam cnt_t FWD_LAST  = lastCount(FL - 1);
  localparam cnt_t BACK_LAST = lastCount(BL);

  state_e           state_q;
  state_e           state_d;
  cnt_t             cnt_q;
  cnt_t             cnt_d;
  logic [WIDTH-1:0] data_q;
  logic             grant1;
  logic             grant2;
  logic             accept;
  logic             arbEn;

  // Gating with rst_n keeps both ready strobes low while reset is held.
  assign arbEn  = (state_q == IDLE) && rst_n;
  assign accept = grant1 | grant2;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req1_i (r1_valid),
    .req2_i (r2_valid),
    .en_i   (arbEn),
    .gnt1_o (grant1),
    .gnt2_o (grant2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // With FL=1 the forward phase is empty, so an accept goes straight to OUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (FL > 1) ? FWD : OUT;
        end
      end
      FWD: begin
        if (cnt_q == FWD_LAST) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      OUT: begin
        if (o_ready) begin
          cnt_d   = '0;
          state_d = (BL > 0) ? BACK : IDLE;
        end
      end
      BACK: begin
        if (cnt_q == BACK_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    r1_ready = grant1;
    r2_ready = grant2;
    o_valid  = (state_q == OUT);
    o_data   = data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= grant2 ? r2_data : r1_data;
    end
  end

`ifdef ARB_MERGE_SRC_EN
  logic src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= 1'b0;
    end else if (accept) begin
      src_q <= grant2;
    end
  end

  assign o_src = src_q;
`endif

endmodule

// File: tb/tb_arbiter_merge_two.sv
// Randomised bench for arbiter_merge_two against a transaction-level timing model.
module tb_arbiter_merge_two;

  localparam int WIDTH = 33;
  localparam int FL    = 2;
  localparam int BL    = 2;

  typedef logic [WIDTH-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  r1_valid, r1_ready, r2_valid, r2_ready;
  word_t r1_data, r2_data, o_data;
  logic  o_valid, o_ready;
`ifdef ARB_MERGE_SRC_EN
  logic  o_src;
`endif

  always #5 clk = ~clk;

  arbiter_merge_two #(.WIDTH(WIDTH), .FL(FL), .BL(BL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_data  (r1_data),
    .r2_valid (r2_valid),
    .r2_ready (r2_ready),
    .r2_data  (r2_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
`ifdef ARB_MERGE_SRC_EN
    .o_src    (o_src),
`endif
    .o_data   (o_data)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Model: one packet in flight, visible FL cycles after accept, next accept BL+1 cycles after handshake.
  word_t r1Q[$], r2Q[$], expQ[$];
  bit    expSrcQ[$];
  int    cyc = 0, accCyc = 0, freeCyc = 0;
  bit    busy = 1'b0, favR2 = 1'b0;

  // Observations taken straight from the DUT pins.
  word_t dutOut[$];
  bit    dutSrc[$];
  int    dutAcc1 = 0, dutAcc2 = 0, dutHs = 0;
  int    dutAccCyc = 0, dutHsCyc = 0, dutLat = -1, dutGap = -1;
  bit    waitValid = 1'b0, sawAcc = 1'b0;

  int    readyMode = 1;
  bit    gapMode   = 1'b0;

  task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: check at the falling edge, then drive producers and o_ready after the rising edge.
  task automatic applyStimulus();
    bit exp1, exp2, expV, obs1, obs2;
    exp1 = 1'b0;
    exp2 = 1'b0;
    @(negedge clk);
    sawAcc = 1'b0;
    obs1 = r1_valid && r1_ready;
    obs2 = r2_valid && r2_ready;
    if (!rst_n) begin
      checkOutput("rst_r1_ready", word_t'(r1_ready), '0);
      checkOutput("rst_r2_ready", word_t'(r2_ready), '0);
      checkOutput("rst_o_valid", word_t'(o_valid), '0);
      checkOutput("rst_o_data", o_data, '0);
`ifdef ARB_MERGE_SRC_EN
      checkOutput("rst_o_src", word_t'(o_src), '0);
`endif
      busy = 1'b0;
      favR2 = 1'b0;
      freeCyc = cyc;
      expQ.delete();
      expSrcQ.delete();
      waitValid = 1'b0;
    end else begin
      if (!busy && cyc >= freeCyc) begin
        if (r1_valid && r2_valid) begin
          exp1 = ~favR2;
          exp2 = favR2;
        end else begin
          exp1 = r1_valid;
          exp2 = r2_valid;
        end
      end
      expV = busy && (cyc >= accCyc + FL);
      checkOutput("r1_ready", word_t'(r1_ready), word_t'(exp1));
      checkOutput("r2_ready", word_t'(r2_ready), word_t'(exp2));
      checkOutput("o_valid", word_t'(o_valid), word_t'(expV));
      if (expV) begin
        checkOutput("o_data", o_data, expQ[0]);
`ifdef ARB_MERGE_SRC_EN
        checkOutput("o_src", word_t'(o_src), word_t'(expSrcQ[0]));
`endif
        if (o_ready) begin
          void'(expQ.pop_front());
          void'(expSrcQ.pop_front());
          busy = 1'b0;
          freeCyc = cyc + BL + 1;
        end
      end
      if (exp1 || exp2) begin
        expQ.push_back(exp2 ? r2_data : r1_data);
        expSrcQ.push_back(exp2);
        busy = 1'b1;
        accCyc = cyc;
        favR2 = exp1;
      end
      if (waitValid && o_valid) begin
        dutLat = cyc - dutAccCyc;
        waitValid = 1'b0;
      end
      if (o_valid && o_ready) begin
        dutOut.push_back(o_data);
        dutHs++;
        dutHsCyc = cyc;
      end
      if (obs1 || obs2) begin
        dutGap = cyc - dutHsCyc;
        dutAccCyc = cyc;
        waitValid = 1'b1;
        sawAcc = 1'b1;
        dutSrc.push_back(obs2);
        if (obs1) dutAcc1++;
        if (obs2) dutAcc2++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (obs1) begin
      void'(r1Q.pop_front());
      r1_valid = 1'b0;
    end
    if (obs2) begin
      void'(r2Q.pop_front());
      r2_valid = 1'b0;
    end
    if (rst_n && !r1_valid && r1Q.size() > 0 && (!gapMode || $urandom_range(0, 2) != 0)) begin
      r1_valid = 1'b1;
      r1_data  = r1Q[0];
    end
    if (rst_n && !r2_valid && r2Q.size() > 0 && (!gapMode || $urandom_range(0, 2) != 0)) begin
      r2_valid = 1'b1;
      r2_data  = r2Q[0];
    end
    case (readyMode)
      0:       o_ready = 1'b0;
      1:       o_ready = 1'b1;
      default: o_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int n = 0;
    while ((r1Q.size() > 0 || r2Q.size() > 0 || r1_valid || r2_valid || busy) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_timeout", word_t'(n >= maxCycles), '0);
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    r1_valid = 1'b0;
    r2_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
  endtask

  initial begin
    int a1, a2, nOut, nHs, n;
    word_t held;
    rst_n    = 1'b0;
    r1_valid = 1'b0;
    r2_valid = 1'b0;
    r1_data  = '0;
    r2_data  = '0;
    o_ready  = 1'b1;
    doReset();

    a1 = dutAcc1; a2 = dutAcc2;
    r1Q.push_back(word_t'(17));
    runUntilIdle(100);
    checkOutput("r1only_acc1", word_t'(dutAcc1 - a1), word_t'(1));
    checkOutput("r1only_acc2", word_t'(dutAcc2 - a2), '0);
    checkOutput("r1only_lat", word_t'(dutLat), word_t'(FL));
    checkOutput("r1only_data", dutOut[$], word_t'(17));

    a1 = dutAcc1; a2 = dutAcc2;
    r2Q.push_back(word_t'(42));
    runUntilIdle(100);
    checkOutput("r2only_acc1", word_t'(dutAcc1 - a1), '0);
    checkOutput("r2only_acc2", word_t'(dutAcc2 - a2), word_t'(1));
    checkOutput("r2only_lat", word_t'(dutLat), word_t'(FL));
    checkOutput("r2only_data", dutOut[$], word_t'(42));

    doReset();
    nOut = dutOut.size();
    r1Q.push_back(word_t'(5));
    r2Q.push_back(word_t'(9));
    runUntilIdle(100);
    checkOutput("simul_count", word_t'(dutOut.size() - nOut), word_t'(2));
    checkOutput("simul_first", dutOut[nOut], word_t'(5));
    checkOutput("simul_second", dutOut[nOut+1], word_t'(9));
    checkOutput("simul_gap", word_t'(dutGap), word_t'(BL + 1));

    nOut = dutOut.size();
    n = dutSrc.size();
    for (int i = 0; i < 15; i++) begin
      r1Q.push_back(word_t'({$urandom(), $urandom()}));
      r2Q.push_back(word_t'({$urandom(), $urandom()}));
    end
    runUntilIdle(2000);
    checkOutput("pairs_count", word_t'(dutOut.size() - nOut), word_t'(30));
    for (int i = n + 1; i < dutSrc.size(); i++) begin
      checkOutput("pairs_alternate", word_t'(dutSrc[i] != dutSrc[i-1]), word_t'(1));
    end

    readyMode = 0;
    r1Q.push_back(word_t'(123));
    r2Q.push_back(word_t'(456));
    n = 0;
    while (!o_valid && n < 30) begin
      applyStimulus();
      n++;
    end
    checkOutput("bp_valid_rise", word_t'(o_valid), word_t'(1));
    held = o_data;
    a1 = dutAcc1 + dutAcc2;
    nHs = dutHs;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("bp_no_accept", word_t'(dutAcc1 + dutAcc2 - a1), '0);
    checkOutput("bp_valid_held", word_t'(o_valid), word_t'(1));
    checkOutput("bp_data_held", o_data, held);
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("bp_one_hs", word_t'(dutHs - nHs), word_t'(1));
    readyMode = 1;
    runUntilIdle(200);

    nOut = dutOut.size();
    r1Q.push_back(word_t'(77));
    n = 0;
    while (!sawAcc && n < 30) begin
      applyStimulus();
      n++;
    end
    checkOutput("midfwd_accept", word_t'(sawAcc), word_t'(1));
    rst_n = 1'b0;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    r1Q.push_back(word_t'(33));
    runUntilIdle(100);
    checkOutput("midfwd_count", word_t'(dutOut.size() - nOut), word_t'(1));
    checkOutput("midfwd_data", dutOut[$], word_t'(33));

    gapMode   = 1'b1;
    readyMode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) r1Q.push_back(word_t'({$urandom(), $urandom()}));
      if ($urandom_range(0, 3) != 0) r2Q.push_back(word_t'({$urandom(), $urandom()}));
    end
    runUntilIdle(4000);
    checkOutput("final_model_empty", word_t'(expQ.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
